word_unpacker: RTL and testbench
================================

// Module: word_unpacker
// PURPOSE
//  Parallel-to-serial unpacker: inverse of the bus-concatenation path. Accepts one
//  WIDTH-bit word over valid/ready, then emits its bits one per accepted beat,
//  MSB first by default, so that {a, b} = word unpacks as a, then b.
//  Sits between the pattern store and single-bit DUT inputs in gate-level
//  fault-simulation test cases.
// PARAMETERS
//  WIDTH      2   bits per input word; legal range 2..64
//  MSB_FIRST  1   1: emit bit WIDTH-1 first; 0: emit bit 0 first
// PORTS
//  clk        in   1      single clock, all state updates on the rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      in_data is valid
//  in_ready   out  1      unpacker accepts a word this cycle
//  in_data    in   WIDTH  parallel word
//  out_valid  out  1      out_bit is valid
//  out_ready  in   1      consumer takes out_bit this cycle
//  out_bit    out  1      current serial bit
//  out_last   out  1      high with the final bit of a word
//  busy       out  1      a word is loaded and not fully drained
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE, shift reg=0, count=0. Outputs after
//    reset: in_ready=1, out_valid=0, out_bit=0, out_last=0, busy=0. Reset
//    mid-word discards the remaining bits, with no partial emission afterwards.
//  - States: IDLE, SHIFT.
//    IDLE : in_ready=1, out_valid=0. On in_valid go to SHIFT, load in_data, count=0.
//    SHIFT: out_valid=1. out_bit = sreg[WIDTH-1] (MSB_FIRST) or sreg[0].
//           On out_ready: shift one place toward the output end (zero fill), count++.
//           out_last = (count==WIDTH-1).
//  - Accept rule: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - in_ready = IDLE | (SHIFT & out_last & out_ready). The last-beat case gives
//    back-to-back words with no bubble.
//  - At the last beat: if in_fire, reload and stay in SHIFT with count=0;
//    otherwise return to IDLE.
//  - Latency: first bit is valid on the cycle after in_fire. A word takes exactly
//    WIDTH out_fire beats.
//  - Backpressure: with out_ready=0, out_bit, out_last and count hold, and
//    in_ready=0 unless IDLE.
//  - in_data is sampled only on in_fire. Changes at other times are ignored.
//  - busy = (state==SHIFT).
//  - Counter width: $clog2(WIDTH), minimum 1. It never wraps past WIDTH-1.
//  - No combinational path from in_data to out_bit.
//  - in_ready depends combinationally on out_ready, and only at the last beat.
// STRUCTURE
//  - Shared package unpack_pkg:
//      typedef enum logic {IDLE, SHIFT} unpack_state_t;
//      function cnt_w(WIDTH).
//  - One sub-module, unpack_shreg: WIDTH-bit load/shift register with direction
//    set by MSB_FIRST. The FSM, counter and handshake stay in word_unpacker.
// TESTING
//  1. rst=1 for 2 cycles, then 0
//     -> in_ready=1, out_valid=0, busy=0, out_bit=0.
//  2. WIDTH=2, MSB_FIRST=1, in_data=2'b10 with out_ready=1
//     -> out_bit = 1, then 0; out_last on the 2nd beat; then IDLE.
//  3. WIDTH=8, MSB_FIRST=0, words 8'hA5 then 8'h3C held valid, out_ready=1
//     -> 16 contiguous beats 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 with no bubble;
//     out_last on beats 8 and 16.
//  4. WIDTH=4, in_data=4'hC, out_ready toggling 1,0,0,1,1,0,1
//     -> out_bit held while stalled; bits 1,1,0,0 appear across 4 fires only.
//  5. WIDTH=4, in_data=4'hF, rst=1 after 2 bits
//     -> next cycle out_valid=0; a new word 4'h0 emits four 0s.
//  6. Random valid/ready, WIDTH=2 and WIDTH=5, 1000 words
//     -> scoreboard repack equals the input words; no word lost or duplicated.

Source files
------------

// File: rtl/unpack_pkg.sv
// Shared definitions for the word unpacker slice.
//
// Contents:
//   unpack_state_t  FSM state encoding (IDLE, SHIFT)
//   cnt_w()         width of the beat counter for a given word width
package unpack_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } unpack_state_t;

  // The beat counter only has to reach width-1. $clog2 gives 0 for a width
  // of 1, so the result is clamped to at least one bit.
  function automatic int cnt_w(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/unpack_shreg.sv
// Load/shift register feeding the serial output of the word unpacker.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, clears the register
//   load       capture load_data (wins over shift when both are high)
//   shift      move one place toward the output end, zero fill
//   load_data  WIDTH-bit parallel word
//   out_bit    bit currently at the output end
//
// With MSB_FIRST=1 the output end is bit WIDTH-1 and the register shifts
// left. With MSB_FIRST=0 the output end is bit 0 and it shifts right.
module unpack_shreg #(
  parameter int WIDTH     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             out_bit
);

  logic [WIDTH-1:0] sreg;

  // Load has priority so that the final beat of one word and the accept of
  // the next word can share a cycle: the last bit leaves while the new word
  // lands. Zero fill means the register drains to all zeros after a full word,
  // which keeps out_bit at 0 while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= load_data;
    end else if (shift) begin
      if (MSB_FIRST) begin
        sreg <= {sreg[WIDTH-2:0], 1'b0};
      end else begin
        sreg <= {1'b0, sreg[WIDTH-1:1]};
      end
    end
  end

  assign out_bit = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

endmodule

// File: rtl/word_unpacker.sv
// Parallel-to-serial unpacker. Accepts one WIDTH-bit word over valid/ready
// and emits its bits one per accepted output beat, MSB first by default.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_data holds a word
//   in_ready   a word is accepted this cycle
//   in_data    parallel input word (sampled only when accepted)
//   out_valid  out_bit holds a bit
//   out_ready  consumer takes out_bit this cycle
//   out_bit    current serial bit (registered, no path from in_data)
//   out_last   final bit of the current word
//   busy       a word is loaded and not fully drained
module word_unpacker
  import unpack_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  unpack_state_t state;
  unpack_state_t state_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          in_fire;
  logic          out_fire;

  // State and beat counter registers. Everything else about the FSM lives
  // in the combinational block below.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Handshake outputs and next-state logic. in_ready opens while shifting
  // only on a last beat that is actually being taken, which lets the next
  // word load in the same cycle the previous one finishes, with no bubble.
  // That is also the only place in_ready looks at out_ready. The counter is
  // forced back to zero whenever a word ends so it never runs past WIDTH-1.
  always_comb begin
    state_next = state;
    count_next = count;
    out_valid  = (state == SHIFT);
    out_last   = (state == SHIFT) && (count == LAST_CNT);
    in_ready   = (state == IDLE) || (out_last && out_ready);
    in_fire    = in_valid && in_ready;
    out_fire   = out_valid && out_ready;
    busy       = (state == SHIFT);

    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = SHIFT;
          count_next = '0;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          if (out_last) begin
            count_next = '0;
            state_next = in_valid ? SHIFT : IDLE;
          end else begin
            count_next = count + CW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  unpack_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (in_fire),
    .shift    (out_fire),
    .load_data(in_data),
    .out_bit  (out_bit)
  );

endmodule

// File: tb/tb_word_unpacker.sv
// Self-checking bench for word_unpacker. Four instances cover the widths and
// bit orders of interest; a negedge monitor repacks every emitted word and
// compares it with the words recorded at acceptance.
module tb_word_unpacker;

  localparam int NI = 4;
  localparam int W [NI] = '{2, 8, 4, 5};
  localparam bit M [NI] = '{1'b1, 1'b0, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic [63:0] in_data   [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic        out_bit   [NI];
  logic        out_last  [NI];
  logic        busy      [NI];

  int total = 0;
  int bad   = 0;

  logic [63:0] word_q [NI][$];
  int          beat   [NI];
  logic [63:0] rep    [NI];
  logic        stalled[NI];
  logic        held_bit [NI];
  logic        held_last[NI];

  always #5 clk = ~clk;

  word_unpacker #(.WIDTH(2), .MSB_FIRST(1'b1)) u_w2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0][1:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_bit(out_bit[0]), .out_last(out_last[0]), .busy(busy[0]));

  word_unpacker #(.WIDTH(8), .MSB_FIRST(1'b0)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1][7:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_bit(out_bit[1]), .out_last(out_last[1]), .busy(busy[1]));

  word_unpacker #(.WIDTH(4), .MSB_FIRST(1'b1)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2][3:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_bit(out_bit[2]), .out_last(out_last[2]), .busy(busy[2]));

  word_unpacker #(.WIDTH(5), .MSB_FIRST(1'b0)) u_w5 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data[3][4:0]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_bit(out_bit[3]), .out_last(out_last[3]), .busy(busy[3]));

  // Count one comparison and report it if the observed value is off.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Offer one word to instance idx and hold it until accepted, with a bound.
  task automatic applyStimulus(input int idx, input logic [63:0] word);
    int  waited;
    logic took;
    waited = 0;
    took   = 1'b0;
    in_valid[idx] = 1'b1;
    in_data[idx]  = word;
    while (!took && waited < 200) begin
      @(negedge clk);
      took = in_ready[idx];
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid[idx] = 1'b0;
    checkOutput("accept_timeout", 64'(took), 64'd1);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active
  // edge, when inputs driven #1 after posedge have settled.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        word_q[i].delete();
        beat[i]    = 0;
        rep[i]     = '0;
        stalled[i] = 1'b0;
      end else begin
        if (stalled[i]) begin
          checkOutput("stall_valid", 64'(out_valid[i]), 64'd1);
          checkOutput("stall_bit", 64'(out_bit[i]), 64'(held_bit[i]));
          checkOutput("stall_last", 64'(out_last[i]), 64'(held_last[i]));
        end
        if (out_valid[i] && !out_ready[i]) begin
          checkOutput("stall_in_ready", 64'(in_ready[i]), 64'd0);
        end
        if (out_valid[i] && out_ready[i]) begin
          if (word_q[i].size() == 0) begin
            checkOutput("extra_beat", 64'd1, 64'd0);
          end else begin
            if (M[i]) rep[i] = (rep[i] << 1) | 64'(out_bit[i]);
            else      rep[i] = rep[i] | (64'(out_bit[i]) << beat[i]);
            checkOutput("last_flag", 64'(out_last[i]), 64'(beat[i] == W[i] - 1));
            beat[i]++;
            if (beat[i] == W[i]) begin
              checkOutput("repack", rep[i], word_q[i].pop_front());
              beat[i] = 0;
              rep[i]  = '0;
            end
          end
        end
        stalled[i]   = out_valid[i] && !out_ready[i];
        held_bit[i]  = out_bit[i];
        held_last[i] = out_last[i];
        if (in_valid[i] && in_ready[i]) begin
          word_q[i].push_back(in_data[i] & ((64'd1 << W[i]) - 64'd1));
        end
      end
    end
  end

  initial begin
    logic [15:0] exp3;
    logic [6:0]  rdy4;
    logic [6:0]  bit4;
    logic [6:0]  last4;
    int          sel;
    bit          rand_on;

    for (int i = 0; i < NI; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      out_ready[i] = 1'b0;
      beat[i]      = 0;
      rep[i]       = '0;
      stalled[i]   = 1'b0;
      held_bit[i]  = 1'b0;
      held_last[i] = 1'b0;
    end

    // 1. reset
    $display("[TB] reset");
    rst = 1'b1;
    idleCycles(2);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checkOutput("rst_in_ready", 64'(in_ready[i]), 64'd1);
      checkOutput("rst_out_valid", 64'(out_valid[i]), 64'd0);
      checkOutput("rst_busy", 64'(busy[i]), 64'd0);
      checkOutput("rst_out_bit", 64'(out_bit[i]), 64'd0);
      checkOutput("rst_out_last", 64'(out_last[i]), 64'd0);
    end
    @(posedge clk);
    #1;

    // 2. WIDTH=2 MSB first, 2'b10
    $display("[TB] width2 msb first");
    out_ready[0] = 1'b1;
    applyStimulus(0, 64'h2);
    @(negedge clk);
    checkOutput("w2_b0_valid", 64'(out_valid[0]), 64'd1);
    checkOutput("w2_b0_bit", 64'(out_bit[0]), 64'd1);
    checkOutput("w2_b0_last", 64'(out_last[0]), 64'd0);
    @(negedge clk);
    checkOutput("w2_b1_bit", 64'(out_bit[0]), 64'd0);
    checkOutput("w2_b1_last", 64'(out_last[0]), 64'd1);
    @(negedge clk);
    checkOutput("w2_idle_valid", 64'(out_valid[0]), 64'd0);
    checkOutput("w2_idle_busy", 64'(busy[0]), 64'd0);
    checkOutput("w2_idle_ready", 64'(in_ready[0]), 64'd1);
    checkOutput("w2_drained", 64'(word_q[0].size()), 64'd0);
    @(posedge clk);
    #1;

    // 3. WIDTH=8 LSB first, A5 then 3C back to back
    $display("[TB] width8 lsb first back to back");
    out_ready[1] = 1'b1;
    exp3 = 16'b1010_0101_0011_1100;
    applyStimulus(1, 64'hA5);
    fork
      applyStimulus(1, 64'h3C);
      begin
        for (int k = 0; k < 16; k++) begin
          @(negedge clk);
          checkOutput("w8_valid", 64'(out_valid[1]), 64'd1);
          checkOutput("w8_bit", 64'(out_bit[1]), 64'(exp3[15-k]));
          checkOutput("w8_last", 64'(out_last[1]), 64'(k == 7 || k == 15));
        end
      end
    join
    @(negedge clk);
    checkOutput("w8_idle_valid", 64'(out_valid[1]), 64'd0);
    checkOutput("w8_drained", 64'(word_q[1].size()), 64'd0);
    @(posedge clk);
    #1;

    // 4. WIDTH=4, 4'hC with out_ready toggling
    $display("[TB] width4 backpressure");
    rdy4  = 7'b1001101;
    bit4  = 7'b1111000;
    last4 = 7'b0000011;
    out_ready[2] = 1'b0;
    applyStimulus(2, 64'hC);
    for (int k = 0; k < 7; k++) begin
      out_ready[2] = rdy4[6-k];
      @(negedge clk);
      checkOutput("w4_valid", 64'(out_valid[2]), 64'd1);
      checkOutput("w4_bit", 64'(out_bit[2]), 64'(bit4[6-k]));
      checkOutput("w4_last", 64'(out_last[2]), 64'(last4[6-k]));
      @(posedge clk);
      #1;
    end
    out_ready[2] = 1'b0;
    @(negedge clk);
    checkOutput("w4_idle_valid", 64'(out_valid[2]), 64'd0);
    checkOutput("w4_drained", 64'(word_q[2].size()), 64'd0);
    @(posedge clk);
    #1;

    // 5. reset mid-word, then a fresh word of zeros
    $display("[TB] width4 reset mid word");
    out_ready[2] = 1'b1;
    applyStimulus(2, 64'hF);
    idleCycles(2);
    rst = 1'b1;
    idleCycles(1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_valid", 64'(out_valid[2]), 64'd0);
    checkOutput("midrst_busy", 64'(busy[2]), 64'd0);
    checkOutput("midrst_bit", 64'(out_bit[2]), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(2, 64'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("zero_valid", 64'(out_valid[2]), 64'd1);
      checkOutput("zero_bit", 64'(out_bit[2]), 64'd0);
    end
    @(negedge clk);
    checkOutput("zero_idle_valid", 64'(out_valid[2]), 64'd0);
    checkOutput("zero_drained", 64'(word_q[2].size()), 64'd0);
    @(posedge clk);
    #1;

    // 6. random valid/ready on WIDTH=2 and WIDTH=5, 500 words each
    $display("[TB] random traffic");
    for (int s = 0; s < 2; s++) begin
      sel = (s == 0) ? 0 : 3;
      rand_on = 1'b1;
      fork
        begin
          for (int n = 0; n < 500; n++) begin
            idleCycles($urandom_range(0, 2));
            applyStimulus(sel, 64'($urandom));
          end
          rand_on = 1'b0;
        end
        begin
          while (rand_on) begin
            out_ready[sel] = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
          end
        end
      join
      out_ready[sel] = 1'b1;
      idleCycles(3 * W[sel]);
      @(negedge clk);
      checkOutput("rand_drained", 64'(word_q[sel].size()), 64'd0);
      checkOutput("rand_busy", 64'(busy[sel]), 64'd0);
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
